// File: rtl/beep_pkg.sv
// beep_pkg: tone codes, FSM encoding and derived-constant helpers shared by the beep checker
package beep_pkg;
  typedef enum logic [1:0] {
    TONE_NONE = 2'b00,
    TONE_LO   = 2'b01,
    TONE_HI   = 2'b10,
    TONE_INV  = 2'b11
  } tone_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FIRST,
    S_IN_SEG,
    S_DONE,
    S_ERR
  } state_t;
  function automatic int half_period(input int clk_hz, input int f_hz);
    return clk_hz / (2 * f_hz);
  endfunction
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return clk_hz * ms / 1000;
  endfunction
endpackage

// File: rtl/beep_detect_if.sv
// beep_detect_if: arm/input lines and status outputs of the beep sequence checker
interface beep_detect_if #(
  parameter int N_SEG = 4
);
  logic                         en;
  logic                         beep_in;
  beep_pkg::tone_t              tone;
  logic [$clog2(N_SEG + 1)-1:0] seg_cnt;
  logic                         busy;
  logic                         done;
  logic                         err;
  modport master (output en, beep_in, input tone, seg_cnt, busy, done, err);
  modport slave (input en, beep_in, output tone, seg_cnt, busy, done, err);
endinterface

// File: rtl/tone_meter.sv
// tone_meter: synchronizes the beep line, measures half periods and confirms the tone class
module tone_meter
  import beep_pkg::*;
#(
  parameter int CLK_HZ = 50000,
  parameter int F_LO   = 250,
  parameter int F_HI   = 500,
  parameter int SIL_MS = 10
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  beep_i,
  output tone_t tone_o
);
  localparam int HP_LO   = half_period(CLK_HZ, F_LO);
  localparam int HP_HI   = half_period(CLK_HZ, F_HI);
  localparam int SIL_CYC = ms_to_cyc(CLK_HZ, SIL_MS);
  localparam int HW      = $clog2(SIL_CYC + 1);
  localparam logic [HW-1:0] SIL    = HW'(SIL_CYC);
  localparam logic [HW-1:0] HI_MIN = HW'(HP_HI - HP_HI / 8);
  localparam logic [HW-1:0] HI_MAX = HW'(HP_HI + HP_HI / 8);
  localparam logic [HW-1:0] LO_MIN = HW'(HP_LO - HP_LO / 8);
  localparam logic [HW-1:0] LO_MAX = HW'(HP_LO + HP_LO / 8);

  logic [2:0]    sync_q;
  logic [HW-1:0] hp_q, hp_d;
  logic          hv_q, hv_d, edge_det, sil;
  tone_t         cls, last_q, last_d, tone_q, tone_d;

  // bits 0..1 form the synchronizer, bit 2 is the previous synchronized level
  assign edge_det = sync_q[2] ^ sync_q[1];
  assign sil      = hp_q == SIL;
  assign tone_o   = tone_q;

  always_comb begin
    cls    = (hp_q >= HI_MIN && hp_q <= HI_MAX) ? TONE_HI :
             (hp_q >= LO_MIN && hp_q <= LO_MAX) ? TONE_LO : TONE_INV;
    hp_d   = edge_det ? HW'(1) : sil ? SIL : hp_q + 1'b1;
    last_d = edge_det ? cls : last_q;
    hv_d   = edge_det ? 1'b1 : sil ? 1'b0 : hv_q;
    tone_d = (edge_det && hv_q && cls == last_q) ? cls :
             (!edge_det && sil) ? TONE_NONE : tone_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      hp_q   <= '0;
      hv_q   <= 1'b0;
      last_q <= TONE_NONE;
      tone_q <= TONE_NONE;
    end else begin
      sync_q <= {sync_q[1:0], beep_i};
      hp_q   <= hp_d;
      hv_q   <= hv_d;
      last_q <= last_d;
      tone_q <= tone_d;
    end
endmodule

// File: rtl/beep_detect.sv
// beep_detect: checks the LO,HI,LO,HI beep pattern with per-segment duration limits
module beep_detect
  import beep_pkg::*;
#(
  parameter int CLK_HZ     = 50000,
  parameter int F_LO       = 250,
  parameter int F_HI       = 500,
  parameter int SEG_MS     = 250,
  parameter int SEG_TOL_MS = 50,
  parameter int SIL_MS     = 10,
  parameter int N_SEG      = 4
) (
  input logic         clk,
  input logic         rst,
  beep_detect_if.slave bus
);
  localparam int SEG_MIN_C = ms_to_cyc(CLK_HZ, SEG_MS - SEG_TOL_MS);
  localparam int SEG_MAX_C = ms_to_cyc(CLK_HZ, SEG_MS + SEG_TOL_MS);
  localparam int SW        = $clog2(N_SEG + 1);
  localparam int TW        = $clog2(SEG_MAX_C + 1);
  localparam logic [TW-1:0] SEG_MIN = TW'(SEG_MIN_C);
  localparam logic [TW-1:0] SEG_MAX = TW'(SEG_MAX_C);
  localparam logic [TW-1:0] ST_SAT  = TW'(SEG_MAX_C + 1);
  localparam logic [SW-1:0] LAST    = SW'(N_SEG - 1);

  tone_t         tone, exp_q, exp_d, opp;
  state_t        state_q, state_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [TW-1:0] st_q, st_d;
  logic          last, in_win;

  tone_meter #(
    .CLK_HZ(CLK_HZ),
    .F_LO  (F_LO),
    .F_HI  (F_HI),
    .SIL_MS(SIL_MS)
  ) u_meter (
    .clk   (clk),
    .rst   (rst),
    .beep_i(bus.beep_in),
    .tone_o(tone)
  );

  assign opp    = (exp_q == TONE_LO) ? TONE_HI : TONE_LO;
  assign last   = seg_q == LAST;
  assign in_win = st_q >= SEG_MIN && st_q <= SEG_MAX;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    seg_d   = seg_q;
    st_d    = st_q;
    if (!bus.en) begin
      state_d = S_IDLE;
      seg_d   = '0;
      st_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_FIRST;
          seg_d   = '0;
          st_d    = '0;
        end
        S_WAIT_FIRST: begin
          state_d = (tone == TONE_LO) ? S_IN_SEG : (tone == TONE_NONE) ? S_WAIT_FIRST : S_ERR;
          exp_d   = TONE_LO;
          st_d    = '0;
        end
        S_IN_SEG: begin
          st_d = (st_q == ST_SAT) ? st_q : st_q + 1'b1;
          if (tone == exp_q) begin
            if (last && st_q >= SEG_MIN) begin
              seg_d   = seg_q + 1'b1;
              state_d = S_DONE;
            end else if (st_q > SEG_MAX) state_d = S_ERR;
          end else if (tone == opp && !last && in_win) begin
            // a confirmed flip to the other tone closes the current segment
            seg_d = seg_q + 1'b1;
            exp_d = opp;
            st_d  = '0;
          end else state_d = S_ERR;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      exp_q   <= TONE_LO;
      seg_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      seg_q   <= seg_d;
      st_q    <= st_d;
    end

  assign bus.tone    = tone;
  assign bus.seg_cnt = seg_q;
  assign bus.busy    = state_q == S_WAIT_FIRST || state_q == S_IN_SEG;
  assign bus.done    = state_q == S_DONE;
  assign bus.err     = state_q == S_ERR;
endmodule
